// File: rtl/ps2_key_filter_if.sv
// Byte-stream and key-event bundle between a PS/2 receiver/consumer and ps2_key_filter.
// The DUT side uses the slave modport; the side that feeds bytes and consumes events uses master.
interface ps2_key_filter_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       enable;
    logic [7:0] ps2_key_data;
    logic       ps2_key_pressed;
    logic       key_ext;
    logic       key_released;
    logic [7:0] last_data_received;
    logic [3:0] tile_idx;
    logic       tile_valid;

    modport master (
        output rx_data, rx_valid, enable,
        input  ps2_key_data, ps2_key_pressed, key_ext, key_released,
        input  last_data_received, tile_idx, tile_valid
    );

    modport slave (
        input  rx_data, rx_valid, enable,
        output ps2_key_data, ps2_key_pressed, key_ext, key_released,
        output last_data_received, tile_idx, tile_valid
    );
endinterface

// File: rtl/ps2_key_filter.sv
// PS/2 scan-code filter: decodes F0/E0 prefixes and suppresses typematic repeats.
// Optional key-to-tile mapping is built when PS2_TILE_MAP_EN is defined.
module ps2_key_filter #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
    input  logic            CLOCK_50,
    input  logic            resetn,
    ps2_key_filter_if.slave bus
);
    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] BRK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE = 8'hE0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BRK    = 2'd1,
        EXT    = 2'd2,
        EXTBRK = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    key_data_q;
    logic [7:0]    last_data_q;
    logic          key_ext_q;
    logic          pressed_q;
    logic          released_q;
    logic [8:0]    held_code_q;
    logic          held_valid_q;

    logic          make_s;
    logic          brk_s;
    logic          ext_s;
    logic [8:0]    code_s;
    logic          accept_s;
    logic          release_hit_s;

    // Prefix decoder next state, prefix timeout and make/break event detection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        make_s   = 1'b0;
        brk_s    = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (bus.rx_valid) begin
            cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (bus.rx_data == BRK_CODE) begin
                        state_d = BRK;
                    end else if (bus.rx_data == EXT_CODE) begin
                        state_d = EXT;
                    end else begin
                        make_s = 1'b1;
                    end
                end
                EXT: begin
                    if (bus.rx_data == BRK_CODE) begin
                        state_d = EXTBRK;
                    end else if (bus.rx_data == EXT_CODE) begin
                        state_d = EXT;
                    end else begin
                        make_s  = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK, EXTBRK: begin
                    if ((bus.rx_data == BRK_CODE) || (bus.rx_data == EXT_CODE)) begin
                        state_d = state_q;
                    end else begin
                        brk_s   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LIMIT) begin
            // a prefix left dangling too long is dropped silently
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign ext_s         = (state_q == EXT) || (state_q == EXTBRK);
    assign code_s        = {ext_s, bus.rx_data};
    assign accept_s      = make_s && !(held_valid_q && (held_code_q == code_s));
    assign release_hit_s = brk_s && held_valid_q && (held_code_q == code_s);

    // Decoder state, timeout counter, held key and registered key outputs
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            key_data_q   <= 8'h00;
            last_data_q  <= 8'h00;
            key_ext_q    <= 1'b0;
            pressed_q    <= 1'b0;
            released_q   <= 1'b0;
            held_code_q  <= 9'h000;
            held_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pressed_q  <= accept_s;
            released_q <= brk_s;
            if (accept_s) begin
                last_data_q  <= key_data_q;
                key_data_q   <= bus.rx_data;
                key_ext_q    <= ext_s;
                held_code_q  <= code_s;
                held_valid_q <= 1'b1;
            end else if (!bus.enable || release_hit_s) begin
                held_valid_q <= 1'b0;
            end else begin
                held_valid_q <= held_valid_q;
            end
        end
    end

    assign bus.ps2_key_data       = key_data_q;
    assign bus.last_data_received = last_data_q;
    assign bus.key_ext            = key_ext_q;
    assign bus.ps2_key_pressed    = pressed_q;
    assign bus.key_released       = released_q;

`ifdef PS2_TILE_MAP_EN
    logic [3:0] tile_idx_q;
    logic       tile_valid_q;
    logic [3:0] tile_s;

    function automatic logic [3:0] tile_of(input logic [7:0] code);
        case (code)
            8'h16:   tile_of = 4'd0;
            8'h1E:   tile_of = 4'd1;
            8'h26:   tile_of = 4'd2;
            8'h25:   tile_of = 4'd3;
            8'h15:   tile_of = 4'd4;
            8'h1D:   tile_of = 4'd5;
            8'h24:   tile_of = 4'd6;
            8'h2D:   tile_of = 4'd7;
            8'h1C:   tile_of = 4'd8;
            8'h1B:   tile_of = 4'd9;
            default: tile_of = 4'hF;
        endcase
    endfunction

    assign tile_s = ext_s ? 4'hF : tile_of(bus.rx_data);

    // Tile lookup registered alongside the press pulse
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            tile_idx_q   <= 4'hF;
            tile_valid_q <= 1'b0;
        end else begin
            tile_valid_q <= accept_s && (tile_s != 4'hF);
            if (accept_s) begin
                tile_idx_q <= tile_s;
            end else begin
                tile_idx_q <= tile_idx_q;
            end
        end
    end

    assign bus.tile_idx   = tile_idx_q;
    assign bus.tile_valid = tile_valid_q;
`else
    assign bus.tile_idx   = 4'hF;
    assign bus.tile_valid = 1'b0;
`endif
endmodule

// File: doc/ps2_key_filter.md
PS2_KEY_FILTER -- requirements
Module: ps2_key_filter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2500000, max idle cycles allowed after an F0/E0 prefix before it is discarded (50 ms at 50 MHz).
REQ-002 CLOCK_50  in  1  sole clock; all state on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 rx_data  in  8  raw byte from PS/2 serial receiver.
REQ-005 rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-006 enable  in  1  filter active (game running); low flushes decode state.
REQ-007 ps2_key_data  out  8  make code of latest accepted keypress.
REQ-008 ps2_key_pressed  out  1  one-cycle pulse per accepted make event.
REQ-009 key_ext  out  1  latest accepted keypress carried E0 prefix.
REQ-010 key_released  out  1  one-cycle pulse per break event.
REQ-011 last_data_received  out  8  ps2_key_data value preceding the latest accepted keypress.
REQ-012 tile_idx  out  4  tile number 0-9 for latest mapped key; 4'hF = none.
REQ-013 tile_valid  out  1  one-cycle pulse, tile_idx valid.

Function
REQ-014 Decoder states SHALL be IDLE, BRK (after F0), EXT (after E0), EXTBRK (after E0 F0); reset/enable-low state IDLE.
REQ-015 IDLE: F0 -> BRK; E0 -> EXT; any other byte b -> make event with ext=0, stay IDLE.
REQ-016 EXT: F0 -> EXTBRK; other byte b -> make event with ext=1, -> IDLE; E0 ignored, stay EXT.
REQ-017 BRK/EXTBRK: byte b not F0/E0 -> break event, -> IDLE; F0/E0 ignored, state unchanged.
REQ-018 Make event SHALL be suppressed (typematic repeat) when held_valid=1 and {ext,b} equals held code; otherwise accepted.
REQ-019 Accepted make: next cycle ps2_key_pressed=1 for one cycle, last_data_received<=old ps2_key_data, ps2_key_data<=b, key_ext<=ext, held code<={ext,b}, held_valid<=1.
REQ-020 Break event: next cycle key_released=1 for one cycle; held_valid cleared only if {ext,b} matches held code.
REQ-021 Latency SHALL be exactly one cycle from rx_valid to output pulse; back-to-back rx_valid each processed, no byte dropped.
REQ-022 Timeout counter SHALL clear on every rx_valid and in IDLE, increment otherwise; on reaching TIMEOUT_CYCLES state -> IDLE, no pulse.
REQ-023 enable=0: state->IDLE, held_valid->0, counter->0, rx_valid ignored, no pulses; data outputs hold.
REQ-024 ps2_key_data, key_ext, last_data_received SHALL change only on accepted make.

Reset
REQ-025 resetn=0 SHALL immediately force: state IDLE, ps2_key_data 8'h00, last_data_received 8'h00, key_ext 0, ps2_key_pressed 0, key_released 0, held_valid 0, held code 0, counter 0, tile_idx 4'hF, tile_valid 0.
REQ-026 Reset during partial prefix sequence SHALL discard the sequence; next byte decoded from IDLE.

Configuration
REQ-027 Macro PS2_TILE_MAP_EN defined: on accepted make with ext=0, codes 16,1E,26,25,15,1D,24,2D,1C,1B map to tile_idx 0-9 with tile_valid pulsing alongside ps2_key_pressed; unmapped or extended codes set tile_idx 4'hF, no tile_valid.
REQ-028 Macro undefined: mapping logic absent; tile_idx constant 4'hF, tile_valid constant 0; ports retained.

Verification
REQ-029 Reset, enable=1, rx 16 -> one cycle later ps2_key_pressed=1, ps2_key_data=16, last_data_received=00, tile_idx=0, tile_valid=1 (macro on).
REQ-030 rx 1E,1E,1E (repeat) -> single press pulse; then F0,1E -> key_released pulse; then 1E -> new press pulse, last_data_received=1E.
REQ-031 rx E0,75 -> press, ps2_key_data=75, key_ext=1, tile_idx=F, no tile_valid; E0,F0,75 -> key_released, held cleared.
REQ-032 rx F0 then no bytes for TIMEOUT_CYCLES -> state IDLE; subsequent 26 -> press with ps2_key_data=26.
REQ-033 rx E0 then enable=0 then enable=1, rx 25 -> press with key_ext=0, ps2_key_data=25; resetn pulse mid-F0 -> outputs reset values, next 1B -> tile_idx=9.
